// File: rtl/bias_stream_buffer.sv
// Bias memory with a programmable per-layer (base,len) table, a valid/ready
// bulk loader, and a backpressured per-channel read stream behind a 2-deep FIFO.
module bias_stream_buffer #(
  parameter int MEM_SIZE   = 64,
  parameter int AWIDTH     = 6,
  parameter int B_BW       = 8,
  parameter int NUM_LAYERS = 4,
  parameter int LWIDTH     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [LWIDTH-1:0] cfg_layer,
  input  logic [AWIDTH-1:0] cfg_base,
  input  logic [AWIDTH:0]   cfg_len,
  input  logic              load_start,
  input  logic [LWIDTH-1:0] load_layer,
  input  logic              load_valid,
  input  logic [B_BW-1:0]   load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic              rd_start,
  input  logic [LWIDTH-1:0] rd_layer,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [B_BW-1:0]   rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;
  localparam int CW = AWIDTH + 1;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] tbl_base_q [NUM_LAYERS];
  logic [AWIDTH-1:0] tbl_base_d [NUM_LAYERS];
  logic [CW-1:0]     tbl_len_q  [NUM_LAYERS];
  logic [CW-1:0]     tbl_len_d  [NUM_LAYERS];
  logic [AWIDTH-1:0] base_q, base_d;
  logic [CW-1:0]     len_q, len_d, wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic              load_ready_q, load_ready_d, load_done_q, load_done_d;
  logic              err_q, err_d;
  logic [B_BW-1:0]   fifo_data_q [2];
  logic [B_BW-1:0]   fifo_data_d [2];
  logic [1:0]        fifo_last_q, fifo_last_d, fifo_cnt_q, fifo_cnt_d;
  logic              infl_q, infl_d, infl_last_q, infl_last_d;

  logic [B_BW-1:0]   mem [MEM_SIZE];
  logic [B_BW-1:0]   rdata_q;

  logic [AWIDTH+1:0] cfg_end;
  logic              cfg_ok, start, start_ok, wr_en, issue, pop;
  logic [LWIDTH-1:0] sel_layer;
  logic [1:0]        occ;
  logic [AWIDTH-1:0] wr_addr, rd_addr;

  always_comb begin
    cfg_end   = {2'b00, cfg_base} + {1'b0, cfg_len};
    cfg_ok    = ({1'b0, cfg_layer} < (LWIDTH+1)'(NUM_LAYERS)) &&
                (cfg_end <= (AWIDTH+2)'(MEM_SIZE));
    start     = load_start | rd_start;
    sel_layer = load_start ? load_layer : rd_layer;
    start_ok  = ({1'b0, sel_layer} < (LWIDTH+1)'(NUM_LAYERS)) &&
                (tbl_len_q[sel_layer] != '0);
    wr_en     = (state_q == LOAD) && load_valid && load_ready_q;
    wr_addr   = base_q + wcnt_q[AWIDTH-1:0];
    rd_addr   = base_q + rcnt_q[AWIDTH-1:0];
    pop       = (fifo_cnt_q != 2'd0) && rd_ready;
    // Occupancy after this cycle's pop: lets a new read issue in the same
    // cycle a beat leaves, which is what keeps the stream bubble-free.
    occ       = fifo_cnt_q - {1'b0, pop};
    issue     = (state_q == READ) && ((occ + {1'b0, infl_q}) < 2'd2) &&
                (rcnt_q < len_q);
  end

  always_comb begin
    state_d      = state_q;
    tbl_base_d   = tbl_base_q;
    tbl_len_d    = tbl_len_q;
    base_d       = base_q;
    len_d        = len_q;
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    load_ready_d = 1'b0;
    load_done_d  = 1'b0;
    err_d        = 1'b0;
    fifo_data_d  = fifo_data_q;
    fifo_last_d  = fifo_last_q;
    fifo_cnt_d   = occ + {1'b0, infl_q};
    infl_d       = issue;
    infl_last_d  = issue && (rcnt_q == len_q - CW'(1));
    if (pop) begin
      fifo_data_d[0] = fifo_data_q[1];
      fifo_last_d[0] = fifo_last_q[1];
    end
    if (infl_q) begin
      fifo_data_d[occ[0]] = rdata_q;
      fifo_last_d[occ[0]] = infl_last_q;
    end
    if (issue) rcnt_d = rcnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          if (cfg_ok) begin
            tbl_base_d[cfg_layer] = cfg_base;
            tbl_len_d[cfg_layer]  = cfg_len;
          end else begin
            err_d = 1'b1;
          end
        end
        if (start) begin
          if (start_ok) begin
            base_d       = tbl_base_q[sel_layer];
            len_d        = tbl_len_q[sel_layer];
            wcnt_d       = '0;
            rcnt_d       = '0;
            state_d      = load_start ? LOAD : READ;
            load_ready_d = load_start;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        load_ready_d = 1'b1;
        if (wr_en) begin
          wcnt_d = wcnt_q + CW'(1);
          if (wcnt_q == len_q - CW'(1)) begin
            load_ready_d = 1'b0;
            load_done_d  = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      READ: if (pop && fifo_last_q[0]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        tbl_base_q[i] <= '0;
        tbl_len_q[i]  <= '0;
      end
      base_q         <= '0;
      len_q          <= '0;
      wcnt_q         <= '0;
      rcnt_q         <= '0;
      load_ready_q   <= 1'b0;
      load_done_q    <= 1'b0;
      err_q          <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      fifo_cnt_q     <= '0;
      infl_q         <= 1'b0;
      infl_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tbl_base_q   <= tbl_base_d;
      tbl_len_q    <= tbl_len_d;
      base_q       <= base_d;
      len_q        <= len_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
      err_q        <= err_d;
      fifo_data_q  <= fifo_data_d;
      fifo_last_q  <= fifo_last_d;
      fifo_cnt_q   <= fifo_cnt_d;
      infl_q       <= infl_d;
      infl_last_q  <= infl_last_d;
    end
  end

  // Plain BRAM: no reset so contents survive rst and the tools can map it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= load_data;
    if (issue) rdata_q <= mem[rd_addr];
  end

  assign load_ready = load_ready_q;
  assign load_done  = load_done_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);
  assign rd_valid   = (fifo_cnt_q != 2'd0);
  assign rd_data    = fifo_data_q[0];
  assign rd_last    = fifo_last_q[0] && rd_valid;
endmodule

// File: doc/bias_stream_buffer.md
Name: bias_stream_buffer

Overview:
- Next-generation bias memory for the accelerator's conv layers (C1/C3/C5 and later layers).
- Replaces fixed per-layer address windows with a runtime-programmable layer table holding a base and length per layer.
- Biases are bulk-loaded through a valid/ready stream and read back as a backpressured stream of one bias per beat, ordered by channel, feeding the MAC array bias adders.
- Sits between the host/DMA loader and the conv engine's bias input.

Parameters:
MEM_SIZE, 64, number of bias words in the block RAM
AWIDTH, 6, address width; must satisfy 2^AWIDTH >= MEM_SIZE
B_BW, 8, bias word width in bits
NUM_LAYERS, 4, number of layer-table entries
LWIDTH, 2, layer index width; must satisfy 2^LWIDTH >= NUM_LAYERS

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_we  in  1  write one layer-table entry
cfg_layer  in  LWIDTH  table entry index
cfg_base  in  AWIDTH  first RAM address of the layer
cfg_len  in  AWIDTH+1  number of biases in the layer
load_start  in  1  begin loading the layer selected by load_layer
load_layer  in  LWIDTH  layer to load
load_valid  in  1  load beat valid
load_data  in  B_BW  bias value
load_ready  out  1  block accepts a load beat
load_done  out  1  one-cycle pulse after the final load beat is written
rd_start  in  1  begin streaming the layer selected by rd_layer
rd_layer  in  LWIDTH  layer to stream
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts the current beat
rd_data  out  B_BW  bias value
rd_last  out  1  marks the final beat of the layer
busy  out  1  state is not IDLE
err  out  1  one-cycle pulse when a command is rejected

Behaviour:
Reset:
- Async reset forces IDLE.
- All outputs go to 0.
- All table entries are cleared to base=0, len=0.
- The read counter, write counter and 2-entry output FIFO are cleared.
- RAM contents are not cleared.
- Reset mid-load or mid-read aborts the operation immediately. No load_done or rd_last is produced.

Configuration:
- cfg_we is accepted only in IDLE, and only when cfg_base+cfg_len <= MEM_SIZE (computed at AWIDTH+2 bits). The entry updates on the next edge.
- Otherwise the table is unchanged and err pulses on the next cycle.

States: IDLE, LOAD, READ.
IDLE:
- load_start has priority over rd_start if both are asserted in the same cycle.
- A start whose selected layer has len==0, or whose layer index is >= NUM_LAYERS, is rejected. err pulses and the state stays IDLE.
- A valid start latches base and len and goes to LOAD or READ.
- start pulses, and cfg_we in states other than IDLE, are ignored. They do not raise err.

LOAD:
- load_ready=1 from the cycle after entry.
- Each cycle with load_valid&&load_ready writes ram[base+wcnt] <= load_data and increments wcnt.
- On the len-th write, load_ready drops the next cycle, load_done pulses in that cycle, and the state returns to IDLE.

READ:
- Address issue is decoupled from output through a 2-entry FIFO, which absorbs the 1-cycle BRAM read latency.
- A read address base+rcnt is issued each cycle in which the FIFO count plus the in-flight read is < 2 and rcnt < len.
- First rd_valid occurs exactly 2 cycles after the rd_start edge.
- With rd_ready held at 1 throughout, throughput is 1 beat per cycle with no bubbles.
- rd_data, rd_valid and rd_last stay stable while rd_valid&&!rd_ready.
- rd_last=1 only with the beat at index len-1.
- The state returns to IDLE on the cycle after the rd_last beat is accepted. busy falls with it.

Width rules:
- Addresses are base+counter; no wrap is possible once the configuration checks pass.
- Counters are AWIDTH+1 bits wide.

Memory:
- The RAM is inferred as block RAM with one write port (LOAD) and one read port (READ).
- LOAD and READ are mutually exclusive, so no read/write collision exists.

Test Plan:
- cfg layer0 base=0 len=2; load 0x11, 0x22; read with rd_ready=1 -> load_done 1 cycle after the 2nd beat; rd_data 0x11 then 0x22 on consecutive cycles; rd_last on 0x22; first rd_valid exactly 2 cycles after rd_start.
- cfg layer2 base=6 len=43 (fills to 48); load values 0..42; read while toggling rd_ready 1,0,0,1 -> all 43 values in order; data held during stalls; no duplicates or drops; rd_last only on value 42.
- cfg base=60 len=5 with MEM_SIZE=64 -> err pulse; table entry unchanged; a later rd_start on that entry (len=0) -> err pulse; busy stays 0.
- load_start and rd_start asserted in the same cycle -> LOAD entered; rd_start ignored; cfg_we during LOAD ignored with no err.
- Assert rst during READ after 3 of 8 beats -> all outputs 0 immediately; table cleared; after re-cfg with the same base/len, a read returns the previously loaded RAM data intact.
- load_valid gapped (1,0,1,1,0,1) for len=4 -> exactly 4 writes at base..base+3; load_done once; load_ready 0 in IDLE before start and after done.
